// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath with a shared memory port and ALU.
// Sequences fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCntl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t     state_q, state_d;
  logic       func_ok;
  logic [3:0] func_alu;
  logic       pc_write_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_write_c, done_c, illegal_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    func_ok  = 1'b1;
    func_alu = ALU_ADD;
    case (Func)
      6'b100000: func_alu = ALU_ADD;
      6'b100010: func_alu = ALU_SUB;
      6'b100100: func_alu = 4'b0000;
      6'b100101: func_alu = 4'b0001;
      6'b100111: func_alu = 4'b1100;
      6'b101010: func_alu = 4'b0111;
      default:   func_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    reg_write_c = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUCntl     = ALU_ADD;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ALUSrcB    = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:     state_d = func_ok ? S_REXEC : S_FETCH;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_IEXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_c = ((Op == OP_RTYPE) && !func_ok) ||
                    !(Op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J});
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUCntl = func_alu;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUCntl    = ALU_SUB;
        PCSrc      = 2'b01;
        pc_write_c = (Op == OP_BNE) ? ~Zero : Zero;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are squashed during reset so an abandoned instruction leaves no side effects
  assign PCWrite    = pc_write_c  & ~reset;
  assign MemRead    = mem_read_c  & ~reset;
  assign MemWrite   = mem_write_c & ~reset;
  assign IRWrite    = ir_write_c  & ~reset;
  assign RegWrite   = reg_write_c & ~reset;
  assign instr_done = done_c      & ~reset;
  assign illegal    = illegal_c   & ~reset;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences are
// generated from the instruction behaviour and compared every cycle.
module tb_multicycle_control;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic       instr_done, illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUCntl, state_o;
  logic [18:0] obs;
  logic [6:0]  strobes;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [18:0] exp_q[$];
  bit          rdy_q[$];
  bit          zero_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(op), .Func(func), .Zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCntl(ALUCntl), .instr_done(instr_done),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUCntl, instr_done, illegal};
  assign strobes = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, instr_done, illegal};

  function automatic logic [18:0] mk(input logic pcw, input logic [1:0] pcsrc,
      input logic iord, input logic mr, input logic mw, input logic irw, input logic rdst,
      input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
      input logic [3:0] alu, input logic done, input logic ill);
    return {pcw, pcsrc, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, alu, done, ill};
  endfunction

  // {supported, alu code} for an R-type function field
  function automatic logic [4:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, ADD};
      6'b100010: return {1'b1, SUB};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b100111: return {1'b1, 4'b1100};
      6'b101010: return {1'b1, 4'b0111};
      default:   return 5'b0_0000;
    endcase
  endfunction

  task automatic push_any(input logic [18:0] v);
    exp_q.push_back(v);
    rdy_q.push_back(1'($urandom_range(0, 1)));
    zero_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_z(input logic [18:0] v, input bit z);
    exp_q.push_back(v);
    rdy_q.push_back(1'($urandom_range(0, 1)));
    zero_q.push_back(z);
  endtask

  task automatic push_wait(input logic [18:0] vw, input logic [18:0] vgo, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(vw);
      rdy_q.push_back(1'b0);
      zero_q.push_back(1'($urandom_range(0, 1)));
    end
    exp_q.push_back(vgo);
    rdy_q.push_back(1'b1);
    zero_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic build(input logic [5:0] o, input logic [5:0] f, input bit z,
                       input int fw, input int mw);
    logic [4:0] fa;
    fa = alu_of(f);
    push_wait(mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 0),
              mk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, ADD, 0, 0), fw);
    if (o == 6'b000000 && fa[4]) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, fa[3:0], 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, ADD, 1, 0));
    end else if (o == 6'b100011) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
      push_wait(mk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 0),
                mk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 0), mw);
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, ADD, 1, 0));
    end else if (o == 6'b101011) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
      push_wait(mk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 0),
                mk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 0), mw);
    end else if (o == 6'b001000) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ADD, 1, 0));
    end else if (o == 6'b000100 || o == 6'b000101) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_z(mk(z ^ (o == 6'b000101), 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 1, 0), z);
    end else if (o == 6'b000010) begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 0));
      push_any(mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 0));
    end else begin
      push_any(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 1));
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the following cycle
  task automatic run_cycles(input string tag, input int n);
    logic [18:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      zero = zero_q.pop_front();
      @(negedge clk);
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s cyc=%0d step=%0d observed=%b expected=%b", tag, cyc, i, obs, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input bit z, input int fw, input int mw);
    op = o;
    func = f;
    build(o, f, z, fw, mw);
    run_cycles(tag, 1000);
  endtask

  task automatic check_reset_strobes(input string tag);
    @(negedge clk);
    checks++;
    assert (strobes === 7'b0) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, strobes, 7'b0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal_funcs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [5:0] ro, rf;

  initial begin
    reset = 1'b1; op = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check_reset_strobes("reset_hold");
    end
    reset = 1'b0;

    do_instr("add", 6'b000000, 6'b100000, 0, 0, 0);
    do_instr("lw_wait2", 6'b100011, 6'b000000, 0, 0, 2);
    do_instr("beq_z1", 6'b000100, 6'b000000, 1, 0, 0);
    do_instr("beq_z0", 6'b000100, 6'b000000, 0, 0, 0);
    do_instr("bne_z1", 6'b000101, 6'b000000, 1, 0, 0);
    do_instr("bne_z0", 6'b000101, 6'b000000, 0, 1, 0);
    do_instr("illegal_op", 6'b111111, 6'b000000, 0, 0, 0);
    do_instr("illegal_func", 6'b000000, 6'b100001, 0, 0, 0);
    do_instr("sw", 6'b101011, 6'b000000, 0, 0, 0);
    do_instr("j", 6'b000010, 6'b000000, 0, 0, 0);
    do_instr("addi", 6'b001000, 6'b000000, 0, 2, 0);
    for (int i = 0; i < 6; i++) do_instr("rtype_func", 6'b000000, legal_funcs[i], 0, 0, 0);

    // Reset while a store is stalled in the memory stage
    op = 6'b101011;
    build(6'b101011, 6'b000000, 0, 0, 5);
    run_cycles("sw_before_reset", 4);
    exp_q.delete(); rdy_q.delete(); zero_q.delete();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    assert (MemWrite === 1'b0) else begin
      failures++;
      $error("FAIL reset_memwr observed=%b expected=%b", MemWrite, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_instr("after_reset", 6'b000000, 6'b100010, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 8))
        0: begin ro = 6'b000000; rf = legal_funcs[$urandom_range(0, 5)]; end
        1: begin ro = 6'b000000; rf = 6'($urandom); end
        2: begin ro = 6'b100011; rf = 6'($urandom); end
        3: begin ro = 6'b101011; rf = 6'($urandom); end
        4: begin ro = 6'b001000; rf = 6'($urandom); end
        5: begin ro = 6'b000100; rf = 6'($urandom); end
        6: begin ro = 6'b000101; rf = 6'($urandom); end
        7: begin ro = 6'b000010; rf = 6'($urandom); end
        default: begin ro = 6'($urandom); rf = 6'($urandom); end
      endcase
      do_instr("random", ro, rf, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
